nios_base_cpu_oci_trace_sched: RTL and testbench

Trace-write scheduler for the Nios OCI debug block. Shares the single trace-memory write port between two producers: the instruction-trace frame source and the data-capture trace (DCT) packer, which delivers a 30-bit `dct_buffer` plus a 4-bit `dct_count`. Tags each accepted item as a 36-bit trace frame and sequences the write address. Handles end-of-test drain with a terminating marker frame, and memory-full and overflow bookkeeping.

---
 rtl/nios_base_oci_trace_pkg.sv | 8 +
 rtl/nios_base_oci_rr_arb2.sv | 16 +
 rtl/nios_base_cpu_oci_trace_sched.sv | 106 ++++++++++
 tb/tb_nios_base_cpu_oci_trace_sched.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/nios_base_oci_trace_pkg.sv
// nios_base_oci_trace_pkg: shared frame tags, frame width and scheduler FSM states
package nios_base_oci_trace_pkg;
   localparam int         FRAME_W = 36;
   localparam logic [1:0] TAG_ITR = 2'b01;
   localparam logic [1:0] TAG_DCT = 2'b10;
   localparam logic [1:0] TAG_END = 2'b11;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/nios_base_oci_rr_arb2.sv
// nios_base_oci_rr_arb2: two-requester round-robin arbiter; req[0]=instruction, req[1]=DCT
module nios_base_oci_rr_arb2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   logic last_dct;
   // a tie goes to whoever did not win last; single requests pass straight through
   always_comb gnt = !en ? 2'b00 : (req == 2'b11) ? (last_dct ? 2'b01 : 2'b10) : req;
   // last-grant starts at DCT so instruction trace wins the first tie
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) last_dct <= 1'b1;
      else if (|gnt) last_dct <= gnt[1];
endmodule

// File: rtl/nios_base_cpu_oci_trace_sched.sv
// nios_base_cpu_oci_trace_sched: trace-memory write scheduler for instruction and DCT frames
// NIOS_BASE_OCI_TRACE_WRAP_EN selects a circular buffer instead of stop-when-full
module nios_base_cpu_oci_trace_sched
   import nios_base_oci_trace_pkg::*;
#(
   parameter int ADDR_W = 7,
   parameter int OVF_W  = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               trc_on,
   input  logic               itr_valid,
   input  logic [33:0]        itr_data,
   output logic               itr_ready,
   input  logic               dct_valid,
   input  logic [29:0]        dct_buffer,
   input  logic [3:0]         dct_count,
   output logic               dct_ready,
   input  logic               test_ending,
   output logic               tw_we,
   output logic [ADDR_W-1:0]  tw_addr,
   output logic [FRAME_W-1:0] tw_data,
   output logic               trc_full,
   output logic               trc_wrap,
   output logic [OVF_W-1:0]   ovf_cnt,
   output logic               drain_done
);
   state_t              state, state_nxt;
   logic [1:0]          gnt;
   logic                arb_en, mark, item, wr, drop;
   logic [ADDR_W-1:0]   ptr;
   logic [FRAME_W-1:0]  frame;

   nios_base_oci_rr_arb2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (arb_en),
      .req     ({dct_valid, itr_valid}),
      .gnt     (gnt)
   );

   // state register
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= S_IDLE;
      else state <= state_nxt;

   // next state; trc_on low beats test_ending while running
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  state_nxt = trc_on ? S_RUN : S_IDLE;
         S_RUN:   state_nxt = !trc_on ? S_IDLE : test_ending ? S_DRAIN : S_RUN;
         S_DRAIN: state_nxt = mark ? S_DONE : S_DRAIN;
         S_DONE:  state_nxt = trc_on ? S_DONE : S_IDLE;
      endcase
   end

   // state-derived outputs and per-cycle write decision
   always_comb begin
      arb_en     = (state == S_RUN) || (state == S_DRAIN);
      drain_done = (state == S_DONE);
      mark       = (state == S_DRAIN) && !itr_valid && !dct_valid;
      itr_ready  = gnt[0];
      dct_ready  = gnt[1];
      item       = gnt[0] || (gnt[1] && dct_count != 4'd0);
      frame      = gnt[0] ? {TAG_ITR, itr_data} :
                   gnt[1] ? {TAG_DCT, dct_count, dct_buffer} : {TAG_END, 34'h0};
      wr         = (item || mark) && !trc_full;
      drop       = item && trc_full;
   end

   // registered write port; tw_addr shows the address of the frame just written
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         tw_we   <= 1'b0;
         tw_addr <= '0;
         tw_data <= '0;
         ptr     <= '0;
      end else begin
         tw_we <= wr;
         if (wr) begin
            tw_addr <= ptr;
            tw_data <= frame;
            ptr     <= ptr + ADDR_W'(1);
         end
      end

   // saturating count of items dropped while full
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) ovf_cnt <= '0;
      else if (drop && !(&ovf_cnt)) ovf_cnt <= ovf_cnt + OVF_W'(1);

`ifdef NIOS_BASE_OCI_TRACE_WRAP_EN
   assign trc_full = 1'b0;
   // sticky: the last address has been written at least once
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) trc_wrap <= 1'b0;
      else if (wr && &ptr) trc_wrap <= 1'b1;
`else
   assign trc_wrap = 1'b0;
   // sticky: the last address has been written, later items are dropped
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) trc_full <= 1'b0;
      else if (wr && &ptr) trc_full <= 1'b1;
`endif
endmodule

// File: tb/tb_nios_base_cpu_oci_trace_sched.sv
// tb_nios_base_cpu_oci_trace_sched: directed bench for the trace write scheduler (ADDR_W=3)
module tb_nios_base_cpu_oci_trace_sched;
   logic        clk = 1'b0;
   logic        reset_n, trc_on, itr_valid, dct_valid, test_ending;
   logic [33:0] itr_data;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        itr_ready, dct_ready, tw_we, trc_full, trc_wrap, drain_done;
   logic [2:0]  tw_addr;
   logic [35:0] tw_data;
   logic [7:0]  ovf_cnt;
   int          n_chk = 0;
   int          n_fail = 0;

   nios_base_cpu_oci_trace_sched #(.ADDR_W(3), .OVF_W(8)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .trc_on      (trc_on),
      .itr_valid   (itr_valid),
      .itr_data    (itr_data),
      .itr_ready   (itr_ready),
      .dct_valid   (dct_valid),
      .dct_buffer  (dct_buffer),
      .dct_count   (dct_count),
      .dct_ready   (dct_ready),
      .test_ending (test_ending),
      .tw_we       (tw_we),
      .tw_addr     (tw_addr),
      .tw_data     (tw_data),
      .trc_full    (trc_full),
      .trc_wrap    (trc_wrap),
      .ovf_cnt     (ovf_cnt),
      .drain_done  (drain_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; trc_on = 1'b0; itr_valid = 1'b1; dct_valid = 1'b1; test_ending = 1'b0;
      itr_data = '0; dct_buffer = '0; dct_count = 4'd1;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      // idle with both producers offering
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_we", tw_we, 0);
         chk("idle_rdy", {itr_ready, dct_ready}, 0);
      end
      chk("idle_outs", {tw_addr, tw_data, trc_full, trc_wrap, ovf_cnt, drain_done}, 0);
      // tie arbitration
      itr_valid = 1'b0; dct_valid = 1'b0; trc_on = 1'b1;
      step();
      itr_valid = 1'b1; dct_valid = 1'b1; itr_data = 34'h1; dct_buffer = 30'h3FF; dct_count = 4'd1;
      for (int i = 0; i < 4; i++) begin
         #1 chk("tie_rdy", {itr_ready, dct_ready}, (i % 2) ? 2'b01 : 2'b10);
         step();
         chk("tie_we", tw_we, 1);
         chk("tie_addr", tw_addr, i);
         chk("tie_tag", tw_data[35:34], (i % 2) ? 2'b10 : 2'b01);
         if (i == 1) chk("tie_dct_data", tw_data, {2'b10, 4'h1, 30'h3FF});
      end
      // zero-count DCT item
      itr_valid = 1'b0; dct_count = 4'd0;
      #1 chk("zero_rdy", dct_ready, 1);
      step();
      chk("zero_we", tw_we, 0);
      chk("zero_addr", tw_addr, 3);
      chk("zero_ovf", ovf_cnt, 0);
      // drop to idle and come back; address must persist
      dct_valid = 1'b0; trc_on = 1'b0;
      step();
      itr_valid = 1'b1; itr_data = 34'h2AAA;
      #1 chk("off_rdy", itr_ready, 0);
      step();
      chk("off_we", tw_we, 0);
      trc_on = 1'b1;
      step();
      chk("on_rdy", itr_ready, 1);
      step();
      chk("resume_we", tw_we, 1);
      chk("resume_addr", tw_addr, 4);
      chk("resume_data", tw_data, {2'b01, 34'h2AAA});
      // drain with two more DCT items, then the end marker
      itr_valid = 1'b0; dct_valid = 1'b1; dct_count = 4'd2; dct_buffer = 30'h15; test_ending = 1'b1;
      step();
      chk("drain1_addr", tw_addr, 5);
      chk("drain1_data", tw_data, {2'b10, 4'h2, 30'h15});
      dct_buffer = 30'h16; test_ending = 1'b0;
      step();
      chk("drain2_we", tw_we, 1);
      chk("drain2_addr", tw_addr, 6);
      chk("drain2_data", tw_data, {2'b10, 4'h2, 30'h16});
      chk("drain2_done", drain_done, 0);
      dct_valid = 1'b0;
      step();
      chk("mark_we", tw_we, 1);
      chk("mark_addr", tw_addr, 7);
      chk("mark_data", tw_data, {2'b11, 34'h0});
      chk("mark_done", drain_done, 1);
`ifdef NIOS_BASE_OCI_TRACE_WRAP_EN
      chk("mark_flags", {trc_full, trc_wrap}, 2'b01);
`else
      chk("mark_flags", {trc_full, trc_wrap}, 2'b10);
`endif
      // DONE holds while trc_on stays high
      itr_valid = 1'b1; dct_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("done_rdy", {itr_ready, dct_ready}, 0);
         step();
         chk("done_hold", drain_done, 1);
         chk("done_we", tw_we, 0);
      end
      itr_valid = 1'b0; dct_valid = 1'b0; trc_on = 1'b0;
      step();
      chk("done_exit", drain_done, 0);
      // reset while a write is pending
      reset_n = 1'b0;
      #1 reset_n = 1'b1; trc_on = 1'b1;
      step();
      itr_valid = 1'b1; itr_data = 34'h3;
      step();
      chk("pre_rst_we", tw_we, 1);
      itr_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1 chk("rst_mid_we", tw_we, 0);
      chk("rst_mid_addr", tw_addr, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      step();
      // fill with ten instruction frames
      itr_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         itr_data = 34'(i);
         #1 chk("fill_rdy", itr_ready, 1);
         step();
`ifdef NIOS_BASE_OCI_TRACE_WRAP_EN
         chk("fill_we", tw_we, 1);
         chk("fill_addr", tw_addr, i % 8);
`else
         chk("fill_we", tw_we, i < 8);
         if (i < 8) chk("fill_addr", tw_addr, i);
`endif
      end
      itr_valid = 1'b0; test_ending = 1'b1;
`ifdef NIOS_BASE_OCI_TRACE_WRAP_EN
      chk("fill_flags", {trc_full, trc_wrap}, 2'b01);
      chk("fill_ovf", ovf_cnt, 0);
`else
      chk("fill_flags", {trc_full, trc_wrap}, 2'b10);
      chk("fill_ovf", ovf_cnt, 2);
`endif
      step();
      step();
      chk("full_done", drain_done, 1);
`ifdef NIOS_BASE_OCI_TRACE_WRAP_EN
      chk("full_mark_we", tw_we, 1);
      chk("full_mark_addr", tw_addr, 2);
`else
      chk("full_mark_we", tw_we, 0);
      chk("full_ovf_keep", ovf_cnt, 2);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
